// File: rtl/fifo_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
// Shared definitions for the FIFO and its read-side streamer.
//   FIFO_WIDTH_DEFAULT : default FIFO data width
//   occ_t              : 2-bit occupancy of the streamer's skid buffer
//   occ_state_e        : skid-buffer control states (EMPTY / ONE / TWO)
// -----------------------------------------------------------------------------
package fifo_pkg;

  localparam int FIFO_WIDTH_DEFAULT = 16;

  typedef logic [1:0] occ_t;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_state_e;

endpackage

// File: rtl/fifo_rd_skid.sv
// -----------------------------------------------------------------------------
// fifo_rd_skid
// Two-entry push/pop buffer that presents its head on a valid/ready stream.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   push       : write push_data into the tail this cycle
//   push_data  : word to store
//   ready      : downstream ready; a pop happens when valid & ready
//   valid      : buffer non-empty
//   data       : buffer head
//   occ        : current occupancy (0..2)
// The caller guarantees no push arrives while the buffer holds two words
// without a simultaneous pop.
// -----------------------------------------------------------------------------
module fifo_rd_skid
  import fifo_pkg::*;
#(
  parameter int FIFO_WIDTH = FIFO_WIDTH_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [FIFO_WIDTH-1:0] push_data,
  input  logic                  ready,
  output logic                  valid,
  output logic [FIFO_WIDTH-1:0] data,
  output occ_t                  occ
);

  occ_state_e            state_q, state_d;
  logic [FIFO_WIDTH-1:0] head_q, tail_q;
  logic                  pop;
  logic                  head_load, head_from_tail, tail_load;

  assign valid = (state_q != OCC_EMPTY);
  assign data  = head_q;
  assign occ   = occ_t'(state_q);
  assign pop   = valid & ready;

  // NOTE: every variable written here gets a default first, so no path
  // through the case leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d        = state_q;
    head_load      = 1'b0;
    head_from_tail = 1'b0;
    tail_load      = 1'b0;
    case (state_q)
      OCC_EMPTY: begin
        if (push) begin
          head_load = 1'b1;
          state_d   = OCC_ONE;
        end
      end
      OCC_ONE: begin
        if (push && pop) begin
          // Head leaves and the captured word replaces it directly.
          head_load = 1'b1;
        end else if (push) begin
          tail_load = 1'b1;
          state_d   = OCC_TWO;
        end else if (pop) begin
          state_d = OCC_EMPTY;
        end
      end
      OCC_TWO: begin
        if (pop) begin
          head_load      = 1'b1;
          head_from_tail = 1'b1;
          if (push) tail_load = 1'b1;
          else      state_d   = OCC_ONE;
        end
      end
      default: state_d = OCC_EMPTY;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (rst) state_q <= OCC_EMPTY;
    else     state_q <= state_d;
  end

  // NOTE: the data registers are reset as well because m_data must read
  // zero after reset, not just be ignored behind m_valid=0.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q <= '0;
      tail_q <= '0;
    end else begin
      if (head_load) head_q <= head_from_tail ? tail_q : push_data;
      if (tail_load) tail_q <= push_data;
    end
  end

endmodule

// File: rtl/fifo_rd_streamer.sv
// -----------------------------------------------------------------------------
// fifo_rd_streamer
// Read-side consumer for the FIFO: issues rd_en, absorbs the FIFO's one-cycle
// registered read latency and presents words on a valid/ready stream.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   en              : permits new FIFO reads (draining continues when low)
//   fifo_empty      : FIFO empty flag
//   fifo_data_out   : FIFO read data, valid the cycle after rd_en
//   fifo_underflow  : FIFO underflow flag aligned with fifo_data_out
//   fifo_rd_en      : read request to the FIFO
//   m_data/m_valid  : stream output
//   m_ready         : stream ready
//   rd_count        : words accepted from the FIFO, wraps
//   underflow_err   : sticky, set when an in-flight read returns underflow
// -----------------------------------------------------------------------------
module fifo_rd_streamer
  import fifo_pkg::*;
#(
  parameter int FIFO_WIDTH = FIFO_WIDTH_DEFAULT,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  fifo_empty,
  input  logic [FIFO_WIDTH-1:0] fifo_data_out,
  input  logic                  fifo_underflow,
  output logic                  fifo_rd_en,
  output logic [FIFO_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [CNT_WIDTH-1:0]  rd_count,
  output logic                  underflow_err
);

  logic       inflight_q;
  occ_t       occ;
  logic       pop;
  logic       push;
  logic [2:0] committed;

  assign pop = m_valid & m_ready;

  // Words already owned by the streamer: buffered plus the one in flight.
  // Capping this at two (or two with a pop freeing a slot) keeps the buffer
  // from ever overflowing under backpressure.
  assign committed  = {1'b0, occ} + {2'b00, inflight_q};
  assign fifo_rd_en = ~rst & en & ~fifo_empty &
                      ((committed < 3'd2) | ((committed == 3'd2) & pop));

  // An underflowed return is dropped rather than buffered.
  assign push = inflight_q & ~fifo_underflow;

  always_ff @(posedge clk) begin
    if (rst) begin
      inflight_q    <= 1'b0;
      rd_count      <= '0;
      underflow_err <= 1'b0;
    end else begin
      inflight_q <= fifo_rd_en;
      if (push)                         rd_count      <= rd_count + CNT_WIDTH'(1);
      if (inflight_q && fifo_underflow) underflow_err <= 1'b1;
    end
  end

  fifo_rd_skid #(
    .FIFO_WIDTH (FIFO_WIDTH)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (fifo_data_out),
    .ready     (m_ready),
    .valid     (m_valid),
    .data      (m_data),
    .occ       (occ)
  );

endmodule
